// File: rtl/kamus_l1d_arbiter.sv
// kamus_l1d_arbiter
// Shares the single L1D request port between the core MEM stage (port C) and
// a debug/DMA master (port D). One transaction is in flight at a time on the
// cache side (req/gnt/rvalid handshake). Ties are broken round-robin. The
// response is routed back to the owning port, and a missing response is
// turned into an error response after TIMEOUT_CYC WAIT cycles.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   c_req_i/we/be/addr/wdata        core request and fields (held until c_gnt_o)
//   c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o   core grant and response
//   d_*                             debug/DMA port, same shape as port C
//   m_req_o/we/be/addr/wdata        request towards the L1D
//   m_gnt_i, m_rvalid_i, m_rdata_i  L1D grant and response
//   busy_o                          a transaction is in progress
//   err_sticky_o                    a timeout has occurred since reset
module kamus_l1d_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                c_req_i,
  input  logic                c_we_i,
  input  logic [DATA_W/8-1:0] c_be_i,
  input  logic [ADDR_W-1:0]   c_addr_i,
  input  logic [DATA_W-1:0]   c_wdata_i,
  output logic                c_gnt_o,
  output logic                c_rvalid_o,
  output logic [DATA_W-1:0]   c_rdata_o,
  output logic                c_err_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_gnt_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                busy_o,
  output logic                err_sticky_o
);

  localparam int BE_W = DATA_W / 8;
  // Counter value seen on the last WAIT cycle before the timeout fires.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_rr_last;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_cnt;
  logic              r_err_sticky;

  logic              w_start;
  logic              w_pick_d;
  logic              w_we;
  logic [BE_W-1:0]   w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_req;
  logic              w_gnt;
  logic              w_resp;
  logic              w_tmo;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    w_start  = c_req_i | d_req_i;
    w_pick_d = 1'b0;
    if (c_req_i && d_req_i) begin
      w_pick_d = (r_rr_last == OWN_C);
    end else begin
      w_pick_d = d_req_i;
    end
    if (w_pick_d) begin
      w_we    = d_we_i;
      w_be    = d_be_i;
      w_addr  = d_addr_i;
      w_wdata = d_wdata_i;
    end else begin
      w_we    = c_we_i;
      w_be    = c_be_i;
      w_addr  = c_addr_i;
      w_wdata = c_wdata_i;
    end
  end

  // Next-state logic; a real response wins over a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_gnt_i) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (m_rvalid_i) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_in_req = (r_state == ST_REQ);
  assign w_gnt    = w_in_req & m_gnt_i;

  // Cache-side request: fields are only presented while the request is up.
  assign m_req_o   = w_in_req;
  assign m_we_o    = w_in_req & r_we;
  assign m_be_o    = w_in_req ? r_be    : {BE_W{1'b0}};
  assign m_addr_o  = w_in_req ? r_addr  : {ADDR_W{1'b0}};
  assign m_wdata_o = w_in_req ? r_wdata : {DATA_W{1'b0}};

  // Requester-side grant/response, steered to the owner only.
  assign c_gnt_o    = w_gnt & (r_owner == OWN_C);
  assign d_gnt_o    = w_gnt & (r_owner == OWN_D);
  assign c_rvalid_o = (w_resp | w_tmo) & (r_owner == OWN_C);
  assign d_rvalid_o = (w_resp | w_tmo) & (r_owner == OWN_D);
  assign c_err_o    = w_tmo & (r_owner == OWN_C);
  assign d_err_o    = w_tmo & (r_owner == OWN_D);
  assign c_rdata_o  = (w_resp && (r_owner == OWN_C)) ? m_rdata_i : {DATA_W{1'b0}};
  assign d_rdata_o  = (w_resp && (r_owner == OWN_D)) ? m_rdata_i : {DATA_W{1'b0}};

  assign busy_o       = (r_state != ST_IDLE);
  assign err_sticky_o = r_err_sticky;

  // State register plus owner, round-robin pointer and latched request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_C;
      r_rr_last <= OWN_D;
      r_we      <= 1'b0;
      r_be      <= {BE_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_start) begin
        r_owner   <= w_pick_d;
        r_rr_last <= w_pick_d;
        r_we      <= w_we;
        r_be      <= w_be;
        r_addr    <= w_addr;
        r_wdata   <= w_wdata;
      end
    end
  end

  // WAIT-cycle counter: cleared on grant, saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 16'd0;
    end else if (w_gnt) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_WAIT) && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_sticky <= 1'b0;
    end else if (w_tmo) begin
      r_err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kamus_l1d_arbiter.sv
// Self-checking bench for kamus_l1d_arbiter. The bench plays both requesters
// and the L1D; expected owners, timing, data and error flags come from a
// transaction-level model (round-robin "last winner" bit, sticky flag).
module tb_kamus_l1d_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          c_req_i, c_we_i, d_req_i, d_we_i;
  logic [BW-1:0] c_be_i, d_be_i;
  logic [AW-1:0] c_addr_i, d_addr_i;
  logic [DW-1:0] c_wdata_i, d_wdata_i;
  logic          c_gnt_o, c_rvalid_o, c_err_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic [DW-1:0] c_rdata_o, d_rdata_o;
  logic          m_req_o, m_we_o, m_gnt_i, m_rvalid_i, busy_o, err_sticky_o;
  logic [BW-1:0] m_be_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o, m_rdata_i;

  kamus_l1d_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_be_i(c_be_i), .c_addr_i(c_addr_i),
    .c_wdata_i(c_wdata_i), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o),
    .c_rdata_o(c_rdata_o), .c_err_o(c_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .busy_o(busy_o), .err_sticky_o(err_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit model_last_d;
  bit model_sticky;

  // Requester fields
  logic          cf_we, df_we;
  logic [BW-1:0] cf_be, df_be;
  logic [AW-1:0] cf_addr, df_addr;
  logic [DW-1:0] cf_wdata, df_wdata;

  // Observations of the last transaction (cycle 0 = cycle requests go up)
  int            o_first_req, o_gnt_cyc, o_rv_cyc;
  int            o_c_gnt, o_d_gnt, o_c_rv, o_d_rv;
  bit            o_win_d, o_err, o_unstable, o_quiet_bad;
  logic          o_we;
  logic [BW-1:0] o_be;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_rdata;

  task automatic rand_fields();
    cf_we = 1'($urandom_range(0, 1)); cf_be = 4'($urandom); cf_addr = $urandom; cf_wdata = $urandom;
    df_we = 1'($urandom_range(0, 1)); df_be = 4'($urandom); df_addr = $urandom; df_wdata = $urandom;
  endtask

  // Plays requesters and memory for one transaction and records what the DUT
  // did. Entered and left 1 time unit after a rising edge with the DUT idle.
  // gdly: REQ cycles before m_gnt_i; rdly: WAIT cycle index of m_rvalid_i (-1 = never).
  task automatic drive_txn(input bit creq, input bit dreq, input int gdly, input int rdly,
                           input logic [DW-1:0] rdata, input int late_c);
    int  req_n, wait_n;
    bit  granted, done;
    c_req_i = creq; c_we_i = cf_we; c_be_i = cf_be; c_addr_i = cf_addr; c_wdata_i = cf_wdata;
    d_req_i = dreq; d_we_i = df_we; d_be_i = df_be; d_addr_i = df_addr; d_wdata_i = df_wdata;
    o_first_req = -1; o_gnt_cyc = -1; o_rv_cyc = -1;
    o_c_gnt = 0; o_d_gnt = 0; o_c_rv = 0; o_d_rv = 0;
    o_win_d = 1'b0; o_err = 1'b0; o_unstable = 1'b0; o_quiet_bad = 1'b0;
    o_rdata = '0;
    req_n = 0; wait_n = 0; granted = 1'b0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (k == late_c) c_req_i = 1'b1;
      m_gnt_i    = m_req_o && (req_n == gdly);
      m_rvalid_i = granted && (wait_n == rdly);
      m_rdata_i  = m_rvalid_i ? rdata : $urandom;
      @(negedge clk_i);
      if (m_req_o) begin
        if (o_first_req < 0) begin
          o_first_req = k; o_we = m_we_o; o_be = m_be_o; o_addr = m_addr_o; o_wdata = m_wdata_o;
        end else if ({m_we_o, m_be_o, m_addr_o, m_wdata_o} !== {o_we, o_be, o_addr, o_wdata}) begin
          o_unstable = 1'b1;
        end
        req_n++;
      end
      if (c_gnt_o || d_gnt_o) begin o_gnt_cyc = k; o_win_d = d_gnt_o; end
      if (c_gnt_o) o_c_gnt++;
      if (d_gnt_o) o_d_gnt++;
      if (c_rvalid_o) o_c_rv++;
      if (d_rvalid_o) o_d_rv++;
      if (c_rvalid_o || d_rvalid_o) begin
        o_rv_cyc = k; done = 1'b1;
        o_rdata  = c_rvalid_o ? c_rdata_o : d_rdata_o;
        o_err    = c_rvalid_o ? c_err_o : d_err_o;
      end
      if ((!c_rvalid_o && (c_rdata_o !== '0 || c_err_o !== 1'b0)) ||
          (!d_rvalid_o && (d_rdata_o !== '0 || d_err_o !== 1'b0))) o_quiet_bad = 1'b1;
      if (granted) wait_n++;
      @(posedge clk_i); #1;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
      if (o_gnt_cyc == k) begin
        granted = 1'b1;
        if (o_win_d) d_req_i = 1'b0; else c_req_i = 1'b0;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL txn_budget: no response within 100 cycles (gnt_cyc=%0d)", o_gnt_cyc);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    c_req_i = 0; c_we_i = 0; c_be_i = 0; c_addr_i = 0; c_wdata_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;
    model_last_d = 1'b1; model_sticky = 1'b0;
    #12;
    n_checks++;
    if ({c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
         m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o, busy_o, err_sticky_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output non-zero (busy=%b m_req=%b)", busy_o, m_req_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_core_read();
    cf_we = 1'b0; cf_be = 4'hF; cf_addr = 32'h100; cf_wdata = $urandom;
    drive_txn(1'b1, 1'b0, 0, 0, 32'hDEADBEEF, -1);
    n_checks++; if (o_first_req !== 1) begin n_fail++; $display("FAIL core_read_req_cyc: got %0d exp 1", o_first_req); end
    n_checks++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin n_fail++; $display("FAIL core_read_addr: got %h we %b exp 100 we 0", o_addr, o_we); end
    n_checks++; if (o_gnt_cyc !== 1 || o_c_gnt !== 1) begin n_fail++; $display("FAIL core_read_gnt: cyc %0d cnt %0d exp 1/1", o_gnt_cyc, o_c_gnt); end
    n_checks++; if (o_rv_cyc !== 2 || o_c_rv !== 1) begin n_fail++; $display("FAIL core_read_rv: cyc %0d cnt %0d exp 2/1", o_rv_cyc, o_c_rv); end
    n_checks++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin n_fail++; $display("FAIL core_read_data: got %h err %b exp deadbeef/0", o_rdata, o_err); end
    n_checks++; if (o_d_gnt !== 0 || o_d_rv !== 0 || o_quiet_bad) begin n_fail++; $display("FAIL core_read_d_quiet: dgnt %0d drv %0d bad %b", o_d_gnt, o_d_rv, o_quiet_bad); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL core_read_idle: busy %b exp 0", busy_o); end
    model_last_d = 1'b0;
  endtask

  task automatic test_round_robin();
    bit exp_d;
    rand_fields();
    for (int t = 0; t < 4; t++) begin
      exp_d = !model_last_d;
      drive_txn(1'b1, 1'b1, 0, 1, $urandom, -1);
      n_checks++; if (o_win_d !== exp_d) begin n_fail++; $display("FAIL rr_owner[%0d]: got d=%b exp d=%b", t, o_win_d, exp_d); end
      n_checks++;
      if ({o_addr, o_wdata} !== (exp_d ? {df_addr, df_wdata} : {cf_addr, cf_wdata}) || o_unstable) begin
        n_fail++; $display("FAIL rr_fields[%0d]: addr %h wdata %h", t, o_addr, o_wdata);
      end
      model_last_d = exp_d;
    end
    // drain the loser of the last tie
    drive_txn(model_last_d ? 1'b1 : 1'b0, model_last_d ? 1'b0 : 1'b1, 0, 0, $urandom, -1);
    n_checks++; if (o_win_d !== !model_last_d) begin n_fail++; $display("FAIL rr_drain: got d=%b exp d=%b", o_win_d, !model_last_d); end
    model_last_d = !model_last_d;
  endtask

  task automatic test_delayed_grant();
    df_we = 1'b1; df_be = 4'b0011; df_addr = $urandom; df_wdata = 32'h1234ABCD;
    cf_we = 1'b0; cf_be = 4'hF; cf_addr = $urandom; cf_wdata = $urandom;
    drive_txn(1'b0, 1'b1, 5, 1, $urandom, 2);
    n_checks++; if (o_win_d !== 1'b1 || o_d_gnt !== 1) begin n_fail++; $display("FAIL dgrant_owner: d=%b dgnt %0d exp 1/1", o_win_d, o_d_gnt); end
    n_checks++; if (o_gnt_cyc !== 6) begin n_fail++; $display("FAIL dgrant_cyc: got %0d exp 6", o_gnt_cyc); end
    n_checks++;
    if (o_unstable || {o_we, o_be, o_wdata} !== {1'b1, 4'b0011, 32'h1234ABCD} || o_addr !== df_addr) begin
      n_fail++; $display("FAIL dgrant_fields: unst %b we %b be %b wdata %h", o_unstable, o_we, o_be, o_wdata);
    end
    n_checks++; if (o_c_gnt !== 0 || o_c_rv !== 0) begin n_fail++; $display("FAIL dgrant_c_blocked: cgnt %0d crv %0d exp 0/0", o_c_gnt, o_c_rv); end
    model_last_d = 1'b1;
    drive_txn(1'b1, 1'b0, 0, 0, $urandom, -1);
    n_checks++; if (o_win_d !== 1'b0 || o_gnt_cyc !== 1) begin n_fail++; $display("FAIL dgrant_c_after: d=%b gnt_cyc %0d exp 0/1", o_win_d, o_gnt_cyc); end
    model_last_d = 1'b0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd;
    int            g;
    rand_fields();
    g = $urandom_range(0, 2);
    drive_txn(1'b1, 1'b0, g, -1, $urandom, -1);
    n_checks++; if (o_rv_cyc !== o_gnt_cyc + TO) begin n_fail++; $display("FAIL tmo_cycle: rv %0d gnt %0d exp gap %0d", o_rv_cyc, o_gnt_cyc, TO); end
    n_checks++; if (o_err !== 1'b1 || o_rdata !== '0 || o_c_rv !== 1) begin n_fail++; $display("FAIL tmo_resp: err %b rdata %h crv %0d", o_err, o_rdata, o_c_rv); end
    model_sticky = 1'b1; model_last_d = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (err_sticky_o !== model_sticky) begin n_fail++; $display("FAIL tmo_sticky: got %b exp 1", err_sticky_o); end
    rd = $urandom;
    drive_txn(1'b1, 1'b0, 0, 1, rd, -1);
    n_checks++; if (o_err !== 1'b0 || o_rdata !== rd) begin n_fail++; $display("FAIL tmo_after_read: err %b rdata %h exp 0/%h", o_err, o_rdata, rd); end
    n_checks++; if (err_sticky_o !== model_sticky) begin n_fail++; $display("FAIL tmo_sticky_hold: got %b exp 1", err_sticky_o); end
  endtask

  task automatic test_race();
    logic [DW-1:0] rd;
    rand_fields();
    rd = $urandom;
    drive_txn(1'b0, 1'b1, 1, TO - 1, rd, -1);
    n_checks++; if (o_rv_cyc !== o_gnt_cyc + TO) begin n_fail++; $display("FAIL race_cycle: rv %0d gnt %0d", o_rv_cyc, o_gnt_cyc); end
    n_checks++; if (o_err !== 1'b0 || o_rdata !== rd || o_d_rv !== 1) begin n_fail++; $display("FAIL race_resp: err %b rdata %h exp 0/%h", o_err, o_rdata, rd); end
    n_checks++; if (err_sticky_o !== model_sticky) begin n_fail++; $display("FAIL race_sticky: got %b exp %b", err_sticky_o, model_sticky); end
    model_last_d = 1'b1;
  endtask

  task automatic test_random();
    bit            pend_c, pend_d, cr, dr, exp_d, exp_err;
    int            gdly, rdly, sel;
    logic [DW-1:0] rd;
    pend_c = 1'b0; pend_d = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cr = pend_c | 1'($urandom_range(0, 1));
      dr = pend_d | 1'($urandom_range(0, 1));
      if (!cr && !dr) begin cr = 1'($urandom_range(0, 1)); dr = !cr; end
      if (!pend_c) begin cf_we = 1'($urandom_range(0, 1)); cf_be = 4'($urandom); cf_addr = $urandom; cf_wdata = $urandom; end
      if (!pend_d) begin df_we = 1'($urandom_range(0, 1)); df_be = 4'($urandom); df_addr = $urandom; df_wdata = $urandom; end
      gdly = $urandom_range(0, 3);
      sel  = $urandom_range(0, 7);
      rdly = (sel == 0) ? -1 : (sel == 1) ? TO - 1 : $urandom_range(0, TO - 2);
      rd   = $urandom;
      exp_d   = (cr && dr) ? !model_last_d : dr;
      exp_err = (rdly < 0);
      drive_txn(cr, dr, gdly, rdly, rd, -1);
      if (exp_err) model_sticky = 1'b1;
      n_checks++; if (o_win_d !== exp_d) begin n_fail++; $display("FAIL rnd_owner[%0d]: got d=%b exp d=%b", i, o_win_d, exp_d); end
      n_checks++; if (o_first_req !== 1 || o_gnt_cyc !== 1 + gdly) begin n_fail++; $display("FAIL rnd_timing[%0d]: req %0d gnt %0d exp 1/%0d", i, o_first_req, o_gnt_cyc, 1 + gdly); end
      n_checks++;
      if (o_unstable || {o_we, o_be, o_addr, o_wdata} !== (exp_d ? {df_we, df_be, df_addr, df_wdata} : {cf_we, cf_be, cf_addr, cf_wdata})) begin
        n_fail++; $display("FAIL rnd_fields[%0d]: we %b be %h addr %h wdata %h unst %b", i, o_we, o_be, o_addr, o_wdata, o_unstable);
      end
      n_checks++;
      if (o_rv_cyc !== o_gnt_cyc + 1 + (exp_err ? TO - 1 : rdly)) begin
        n_fail++; $display("FAIL rnd_rv_cyc[%0d]: got %0d gnt %0d rdly %0d", i, o_rv_cyc, o_gnt_cyc, rdly);
      end
      n_checks++;
      if (o_err !== exp_err || o_rdata !== (exp_err ? 32'h0 : rd)) begin
        n_fail++; $display("FAIL rnd_resp[%0d]: err %b rdata %h exp %b/%h", i, o_err, o_rdata, exp_err, exp_err ? 32'h0 : rd);
      end
      n_checks++;
      if ({o_c_gnt, o_d_gnt, o_c_rv, o_d_rv} !== (exp_d ? {32'd0, 32'd1, 32'd0, 32'd1} : {32'd1, 32'd0, 32'd1, 32'd0}) || o_quiet_bad) begin
        n_fail++; $display("FAIL rnd_routing[%0d]: cg %0d dg %0d cr %0d dr %0d bad %b", i, o_c_gnt, o_d_gnt, o_c_rv, o_d_rv, o_quiet_bad);
      end
      n_checks++; if (err_sticky_o !== model_sticky) begin n_fail++; $display("FAIL rnd_sticky[%0d]: got %b exp %b", i, err_sticky_o, model_sticky); end
      model_last_d = exp_d;
      pend_c = cr && exp_d;
      pend_d = dr && !exp_d;
    end
    if (pend_c || pend_d) begin
      drive_txn(pend_c, pend_d, 0, 0, $urandom, -1);
      n_checks++; if (o_win_d !== pend_d) begin n_fail++; $display("FAIL rnd_drain: got d=%b exp d=%b", o_win_d, pend_d); end
      model_last_d = pend_d;
    end
  endtask

  task automatic test_reset_mid_wait();
    bit saw_rv;
    cf_we = 1'b0; cf_be = 4'hF; cf_addr = $urandom; cf_wdata = $urandom;
    // reset while the request is up
    c_req_i = 1'b1; d_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if (m_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup: m_req %b exp 1", m_req_o); end
    #2; rst_ni = 1'b0; #1;
    n_checks++; if (m_req_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_req: m_req %b busy %b exp 0/0", m_req_o, busy_o); end
    c_req_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // reset while waiting for the response
    c_req_i = 1'b1; m_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    c_req_i = 1'b0;
    @(posedge clk_i); #1;
    m_gnt_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1 || m_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_wait_setup: busy %b m_req %b exp 1/0", busy_o, m_req_o); end
    #2; rst_ni = 1'b0; #1;
    n_checks++;
    if (busy_o !== 1'b0 || m_req_o !== 1'b0 || c_rvalid_o !== 1'b0 || err_sticky_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_wait: busy %b m_req %b crv %b sticky %b exp 0", busy_o, m_req_o, c_rvalid_o, err_sticky_o);
    end
    model_last_d = 1'b1; model_sticky = 1'b0;
    saw_rv = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = $urandom;
    @(negedge clk_i);
    if (c_rvalid_o || d_rvalid_o) saw_rv = 1'b1;
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (c_rvalid_o || d_rvalid_o || busy_o) saw_rv = 1'b1;
    end
    n_checks++; if (saw_rv) begin n_fail++; $display("FAIL rst_no_rvalid: response or busy seen after abandoned txn"); end
    m_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rand_fields();
    drive_txn(1'b1, 1'b1, 0, 0, $urandom, -1);
    n_checks++; if (o_win_d !== 1'b0) begin n_fail++; $display("FAIL rst_core_first: got d=%b exp d=0", o_win_d); end
    drive_txn(1'b0, 1'b1, 0, 0, $urandom, -1);
    n_checks++; if (o_win_d !== 1'b1) begin n_fail++; $display("FAIL rst_drain_d: got d=%b exp d=1", o_win_d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_core_read();
    test_round_robin();
    test_delayed_grant();
    test_timeout();
    test_race();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
